// File: rtl/reorder_buffer_pkg.sv
// Shared sizing and entry types for the reorder buffer.
// Type codes match the decoder's dec_type encoding.
package reorder_buffer_pkg;
  localparam int ROB_SIZE       = 8;
  localparam int ROB_WIDTH      = 3;
  localparam int ROB_TYPE_WIDTH = 3;

  typedef enum logic [ROB_TYPE_WIDTH-1:0] {
    ROB_REG    = 3'd0,
    ROB_STORE  = 3'd1,
    ROB_BRANCH = 3'd2,
    ROB_JALR   = 3'd3,
    ROB_HALT   = 3'd4
  } rob_type_e;

  typedef struct packed {
    rob_type_e   typ;
    logic [4:0]  rd;
    logic [31:0] value;
    logic [31:0] jump_addr;
    logic        pred_taken;
    logic [31:0] alt_addr;
  } rob_entry_t;
endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates from the decoder, takes out-of-order
// writeback from RS/LSB, commits in order and raises the global flush on redirects.
module reorder_buffer #(
  parameter int ROB_SIZE  = reorder_buffer_pkg::ROB_SIZE,
  parameter int ROB_WIDTH = reorder_buffer_pkg::ROB_WIDTH
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  output logic                 dec_full,
  input  logic                 dec_rdy,
  output logic [ROB_WIDTH-1:0] dec_rob_id,
  input  logic [2:0]           dec_type,
  input  logic [4:0]           dec_rd,
  input  logic [31:0]          dec_value,
  input  logic                 dec_ready,
  input  logic                 dec_pred_taken,
  input  logic [31:0]          dec_alt_addr,
  input  logic [ROB_WIDTH-1:0] query_j_id,
  input  logic [ROB_WIDTH-1:0] query_k_id,
  output logic                 query_j_ready,
  output logic                 query_k_ready,
  output logic [31:0]          query_j_data,
  output logic [31:0]          query_k_data,
  input  logic                 rs_rdy,
  input  logic [ROB_WIDTH-1:0] rs_rob_id,
  input  logic [31:0]          rs_data,
  input  logic                 rs_set_jump_addr,
  input  logic                 lsb_rdy,
  input  logic [ROB_WIDTH-1:0] lsb_rob_id,
  input  logic [31:0]          lsb_data,
  output logic                 rf_en,
  output logic [4:0]           rf_rd,
  output logic [31:0]          rf_data,
  output logic [ROB_WIDTH-1:0] rf_rob_id,
  output logic                 lsb_commit_en,
  output logic [ROB_WIDTH-1:0] lsb_commit_rob_id,
  output logic                 flush,
  output logic [31:0]          flush_pc,
  output logic                 halt
);
  import reorder_buffer_pkg::*;

  localparam logic [ROB_WIDTH:0] FULL_CNT = (ROB_WIDTH+1)'(ROB_SIZE);

  rob_entry_t [ROB_SIZE-1:0] ent_q;
  logic [ROB_SIZE-1:0]       valid_q, ready_q;
  logic [ROB_WIDTH-1:0]      head_q, tail_q;
  logic [ROB_WIDTH:0]        count_q;
  rob_entry_t                head_ent;
  logic                      commit, alloc, wb_en;

  assign head_ent   = ent_q[head_q];
  assign dec_full   = (count_q == FULL_CNT);
  assign dec_rob_id = tail_q;
  assign alloc      = rdy_in && dec_rdy && !flush;
  assign wb_en      = rdy_in && !flush;
  // ready is registered, so a writeback to head is seen here one cycle later
  assign commit     = rdy_in && !flush && !halt && (count_q != '0) && ready_q[head_q];

  assign rf_en             = commit && (head_ent.typ == ROB_REG || head_ent.typ == ROB_JALR);
  assign rf_rd             = head_ent.rd;
  assign rf_data           = head_ent.value;
  assign rf_rob_id         = head_q;
  assign lsb_commit_en     = commit && (head_ent.typ == ROB_STORE);
  assign lsb_commit_rob_id = head_q;

  // Operand lookup: same-cycle RS value beats LSB beats stored entry; a free tag reads as ready.
  function automatic logic [32:0] query(input logic [ROB_WIDTH-1:0] id);
    if (rs_rdy && !rs_set_jump_addr && rs_rob_id == id) return {1'b1, rs_data};
    if (lsb_rdy && lsb_rob_id == id) return {1'b1, lsb_data};
    return {ready_q[id] || !valid_q[id], ent_q[id].value};
  endfunction

  assign {query_j_ready, query_j_data} = query(query_j_id);
  assign {query_k_ready, query_k_data} = query(query_k_id);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ent_q    <= '0;
      valid_q  <= '0;
      ready_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      flush    <= 1'b0;
      flush_pc <= 32'd0;
      halt     <= 1'b0;
    end else if (rdy_in) begin
      if (flush) begin
        valid_q <= '0;
        ready_q <= '0;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        flush   <= 1'b0;
      end else begin
        if (commit) begin
          valid_q[head_q] <= 1'b0;
          ready_q[head_q] <= 1'b0;
          head_q          <= head_q + 1'b1;
          case (head_ent.typ)
            ROB_JALR: begin
              flush    <= 1'b1;
              flush_pc <= head_ent.jump_addr;
            end
            ROB_BRANCH: if (head_ent.value[0] != head_ent.pred_taken) begin
              flush    <= 1'b1;
              flush_pc <= head_ent.alt_addr;
            end
            ROB_HALT: halt <= 1'b1;
            default: ;
          endcase
        end
        if (alloc) begin
          ent_q[tail_q] <= '{typ: rob_type_e'(dec_type), rd: dec_rd, value: dec_value,
                             jump_addr: 32'd0, pred_taken: dec_pred_taken,
                             alt_addr: dec_alt_addr};
          valid_q[tail_q] <= 1'b1;
          ready_q[tail_q] <= dec_ready;
          tail_q          <= tail_q + 1'b1;
        end
        if (wb_en && rs_rdy) begin
          ready_q[rs_rob_id] <= 1'b1;
          if (rs_set_jump_addr) ent_q[rs_rob_id].jump_addr <= rs_data;
          else                  ent_q[rs_rob_id].value     <= rs_data;
        end
        if (wb_en && lsb_rdy) begin
          ready_q[lsb_rob_id]     <= 1'b1;
          ent_q[lsb_rob_id].value <= lsb_data;
        end
        case ({alloc, commit})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer; commits are checked against an in-order scoreboard.
module tb_reorder_buffer;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        dec_full, dec_rdy, dec_ready, dec_pred_taken;
  logic [2:0]  dec_rob_id, dec_type;
  logic [4:0]  dec_rd;
  logic [31:0] dec_value, dec_alt_addr;
  logic [2:0]  query_j_id, query_k_id;
  logic        query_j_ready, query_k_ready;
  logic [31:0] query_j_data, query_k_data;
  logic        rs_rdy, rs_set_jump_addr, lsb_rdy;
  logic [2:0]  rs_rob_id, lsb_rob_id;
  logic [31:0] rs_data, lsb_data;
  logic        rf_en, lsb_commit_en, flush, halt;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data, flush_pc;
  logic [2:0]  rf_rob_id, lsb_commit_rob_id;

  reorder_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .dec_full(dec_full), .dec_rdy(dec_rdy), .dec_rob_id(dec_rob_id),
    .dec_type(dec_type), .dec_rd(dec_rd), .dec_value(dec_value), .dec_ready(dec_ready),
    .dec_pred_taken(dec_pred_taken), .dec_alt_addr(dec_alt_addr),
    .query_j_id(query_j_id), .query_k_id(query_k_id),
    .query_j_ready(query_j_ready), .query_k_ready(query_k_ready),
    .query_j_data(query_j_data), .query_k_data(query_k_data),
    .rs_rdy(rs_rdy), .rs_rob_id(rs_rob_id), .rs_data(rs_data),
    .rs_set_jump_addr(rs_set_jump_addr),
    .lsb_rdy(lsb_rdy), .lsb_rob_id(lsb_rob_id), .lsb_data(lsb_data),
    .rf_en(rf_en), .rf_rd(rf_rd), .rf_data(rf_data), .rf_rob_id(rf_rob_id),
    .lsb_commit_en(lsb_commit_en), .lsb_commit_rob_id(lsb_commit_rob_id),
    .flush(flush), .flush_pc(flush_pc), .halt(halt)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        is_store;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [2:0]  id;
  } exp_t;

  exp_t sb[$];
  int vectors = 0, miscompares = 0, ncommit = 0;
  int c0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic st, input logic [4:0] rd, input logic [31:0] d, input logic [2:0] id);
    exp_t e;
    e.is_store = st; e.rd = rd; e.data = d; e.id = id;
    sb.push_back(e);
  endtask

  // Settle, score any commit strobe against the queue head, then advance one clock.
  task automatic step();
    exp_t e;
    #1;
    if (rf_en === 1'b1 || lsb_commit_en === 1'b1) begin
      ncommit++;
      if (sb.size() == 0) chk("unexpected_commit", 32'({rf_en, lsb_commit_en}), 32'd0);
      else begin
        e = sb.pop_front();
        chk("commit_store_en", 32'(lsb_commit_en), 32'(e.is_store));
        chk("commit_rf_en", 32'(rf_en), 32'(!e.is_store));
        if (e.is_store) chk("commit_store_id", 32'(lsb_commit_rob_id), 32'(e.id));
        else begin
          chk("commit_rd", 32'(rf_rd), 32'(e.rd));
          chk("commit_data", rf_data, e.data);
          chk("commit_id", 32'(rf_rob_id), 32'(e.id));
        end
      end
    end
    @(posedge clk_in); #1;
  endtask

  task automatic clear();
    dec_rdy = 1'b0; rs_rdy = 1'b0; rs_set_jump_addr = 1'b0; lsb_rdy = 1'b0;
  endtask

  task automatic alloc(input logic [2:0] t, input logic [4:0] rd, input logic [31:0] v,
                       input logic r, input logic p, input logic [31:0] a);
    dec_rdy = 1'b1; dec_type = t; dec_rd = rd; dec_value = v;
    dec_ready = r; dec_pred_taken = p; dec_alt_addr = a;
  endtask

  task automatic rs_wb(input logic [2:0] id, input logic [31:0] d, input logic j);
    rs_rdy = 1'b1; rs_rob_id = id; rs_data = d; rs_set_jump_addr = j;
  endtask

  task automatic do_reset();
    clear();
    rst_in = 1'b1; step(); step(); rst_in = 1'b0;
    sb.delete();
  endtask

  initial begin
    rdy_in = 1'b1; dec_type = 3'd0; dec_rd = 5'd0; dec_value = 32'd0; dec_ready = 1'b0;
    dec_pred_taken = 1'b0; dec_alt_addr = 32'd0; query_j_id = 3'd0; query_k_id = 3'd0;
    rs_rob_id = 3'd0; rs_data = 32'd0; lsb_rob_id = 3'd0; lsb_data = 32'd0;
    do_reset();
    chk("reset_full", 32'(dec_full), 32'd0);
    chk("reset_tail", 32'(dec_rob_id), 32'd0);
    chk("reset_flush", 32'(flush), 32'd0);
    chk("reset_flush_pc", flush_pc, 32'd0);
    chk("reset_halt", 32'(halt), 32'd0);
    chk("reset_rf_en", 32'(rf_en), 32'd0);

    // 1: single REG through RS writeback
    alloc(3'd0, 5'd5, 32'd0, 1'b0, 1'b0, 32'd0); step(); clear();
    rs_wb(3'd0, 32'h1234, 1'b0); push(1'b0, 5'd5, 32'h1234, 3'd0); step(); clear();
    step();
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);
    chk("t1_tail", 32'(dec_rob_id), 32'd1);
    chk("t1_full", 32'(dec_full), 32'd0);
    step();
    chk("t1_ncommit", 32'(ncommit), 32'd1);

    // 2: fill, then complete out of order
    do_reset();
    for (int i = 0; i < 8; i++) begin
      alloc(3'd0, 5'(10 + i), 32'd0, 1'b0, 1'b0, 32'd0); step();
    end
    clear();
    chk("t2_full", 32'(dec_full), 32'd1);
    chk("t2_tail_wrap", 32'(dec_rob_id), 32'd0);
    for (int k = 0; k < 4; k++) push(1'b0, 5'(10 + k), 32'hA0 + 32'(k), 3'(k));
    rs_wb(3'd3, 32'hA3, 1'b0); step();
    rs_wb(3'd0, 32'hA0, 1'b0); step();
    c0 = ncommit;
    rs_wb(3'd1, 32'hA1, 1'b0);
    chk("t2_full_before", 32'(dec_full), 32'd1);
    step();
    chk("t2_commit0", 32'(ncommit), 32'(c0 + 1));
    chk("t2_full_drop", 32'(dec_full), 32'd0);
    rs_wb(3'd2, 32'hA2, 1'b0); step(); clear();
    chk("t2_commit1", 32'(ncommit), 32'(c0 + 2));
    step();
    chk("t2_commit2", 32'(ncommit), 32'(c0 + 3));
    step();
    chk("t2_commit3", 32'(ncommit), 32'(c0 + 4));
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);

    // 3: mispredicted branch flushes a younger ready REG
    do_reset();
    alloc(3'd2, 5'd0, 32'd0, 1'b0, 1'b0, 32'h40); step();
    alloc(3'd0, 5'd7, 32'h77, 1'b1, 1'b0, 32'd0); step(); clear();
    rs_wb(3'd0, 32'd1, 1'b0); step(); clear();
    step();
    chk("t3_flush", 32'(flush), 32'd1);
    chk("t3_flush_pc", flush_pc, 32'h40);
    alloc(3'd0, 5'd8, 32'h88, 1'b1, 1'b0, 32'd0);
    chk("t3_rf_en_in_flush", 32'(rf_en), 32'd0);
    step(); clear();
    chk("t3_flush_drop", 32'(flush), 32'd0);
    chk("t3_tail_zero", 32'(dec_rob_id), 32'd0);
    c0 = ncommit;
    step(); step();
    chk("t3_no_commit", 32'(ncommit), 32'(c0));

    // 4: JALR commits link value and redirects to jump target
    alloc(3'd3, 5'd1, 32'h104, 1'b0, 1'b0, 32'd0); step(); clear();
    rs_wb(3'd0, 32'h200, 1'b1); push(1'b0, 5'd1, 32'h104, 3'd0); step(); clear();
    step();
    chk("t4_flush", 32'(flush), 32'd1);
    chk("t4_flush_pc", flush_pc, 32'h200);
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);
    step();

    // 5: simultaneous LSB and RS writeback
    alloc(3'd1, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0); step();
    alloc(3'd0, 5'd9, 32'd0, 1'b0, 1'b0, 32'd0); step(); clear();
    lsb_rdy = 1'b1; lsb_rob_id = 3'd0; lsb_data = 32'hAA;
    rs_wb(3'd1, 32'h55, 1'b0);
    push(1'b1, 5'd0, 32'd0, 3'd0); push(1'b0, 5'd9, 32'h55, 3'd1);
    step(); clear(); step(); step();
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);

    // 6: query bypass and rdy_in stall
    do_reset();
    for (int i = 0; i < 3; i++) begin
      alloc(3'd0, 5'(20 + i), 32'd0, 1'b0, 1'b0, 32'd0); step();
    end
    clear();
    query_j_id = 3'd2; query_k_id = 3'd1; #1;
    chk("t6_j_not_ready", 32'(query_j_ready), 32'd0);
    rs_wb(3'd2, 32'hBEEF, 1'b0);
    lsb_rdy = 1'b1; lsb_rob_id = 3'd1; lsb_data = 32'h11; #1;
    chk("t6_j_ready", 32'(query_j_ready), 32'd1);
    chk("t6_j_data", query_j_data, 32'hBEEF);
    chk("t6_k_ready", 32'(query_k_ready), 32'd1);
    chk("t6_k_data", query_k_data, 32'h11);
    step(); clear();
    rdy_in = 1'b0; query_j_id = 3'd0;
    rs_wb(3'd0, 32'h300, 1'b1); #1;
    chk("t6_jump_wb_not_ready", 32'(query_j_ready), 32'd0);
    c0 = ncommit;
    for (int i = 0; i < 3; i++) step();
    chk("t6_stall_no_commit", 32'(ncommit), 32'(c0));
    chk("t6_stall_tail", 32'(dec_rob_id), 32'd3);
    clear(); rdy_in = 1'b1;
    rs_wb(3'd0, 32'h100, 1'b0);
    push(1'b0, 5'd20, 32'h100, 3'd0); push(1'b0, 5'd21, 32'h11, 3'd1);
    push(1'b0, 5'd22, 32'hBEEF, 3'd2);
    step(); clear(); step(); step(); step();
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);

    // halt is sticky and blocks further commits until reset
    alloc(3'd4, 5'd0, 32'd0, 1'b1, 1'b0, 32'd0); step(); clear();
    step();
    chk("halt_set", 32'(halt), 32'd1);
    alloc(3'd0, 5'd1, 32'h5, 1'b1, 1'b0, 32'd0); step(); clear();
    c0 = ncommit;
    step(); step();
    chk("halt_blocks_commit", 32'(ncommit), 32'(c0));
    chk("halt_sticky", 32'(halt), 32'd1);
    do_reset();
    chk("halt_reset", 32'(halt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
